// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment read-back monitor.
// Segment constants are active-high, bit6=g .. bit0=a.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } decoded_t;

  // Bits needed for a counter that must hold values 0..stable_cycles.
  function automatic int stable_cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low gfedcba pattern back to a BCD digit.
// Anything that is not one of the ten digit shapes reports DIGIT_INVALID with err set.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output decoded_t   dec
);

  // Match the lit segments against the ten legal digit shapes.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    dec = '{err: 1'b0, digit: 4'd0};
    case (~seg_n)
      SEG_0:   dec.digit = 4'd0;
      SEG_1:   dec.digit = 4'd1;
      SEG_2:   dec.digit = 4'd2;
      SEG_3:   dec.digit = 4'd3;
      SEG_4:   dec.digit = 4'd4;
      SEG_5:   dec.digit = 4'd5;
      SEG_6:   dec.digit = 4'd6;
      SEG_7:   dec.digit = 4'd7;
      SEG_8:   dec.digit = 4'd8;
      SEG_9:   dec.digit = 4'd9;
      default: dec = '{err: 1'b1, digit: DIGIT_INVALID};
    endcase
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Read-back monitor for a multiplexed active-low 7-segment display.
// Synchronizes the segment/anode bus, waits for a stable single-anode sample,
// decodes it into the matching digit slot and hands out complete frames on a
// valid/ready interface, pulsing overrun when a finished frame cannot be taken.
// Optional: define SEG_READER_ERR_CNT_EN to add err_count, a saturating count of
// captures whose pattern was not a digit.
module seven_segment_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
`ifdef SEG_READER_ERR_CNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int SAMPLE_W = NUM_DIGITS + 7;
  localparam int CNT_W    = stable_cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [SAMPLE_W-1:0] sync_q1, sync_q2, prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_next;
  logic                sample_changed, reach, one_hot, capture;
  logic [NUM_DIGITS-1:0] an_act, capture_mask;
  logic [6:0]          seg_s;
  decoded_t            dec;

  logic [NUM_DIGITS-1:0][3:0] slot_digit_q;
  logic [NUM_DIGITS-1:0]      slot_err_q;
  logic [NUM_DIGITS-1:0]      filled_q;
  logic                       frame_done, load;

  // Two-flop synchronizer on the whole {an,seg} bus, plus last cycle's sample for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
    end else begin
      // NOTE: sequential state uses <= so each flop takes the value from before the edge.
      sync_q1 <= {an_in, seg_in};
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign an_act         = ~sync_q2[SAMPLE_W-1:7];
  assign seg_s          = sync_q2[6:0];
  assign sample_changed = (sync_q2 != prev_q);
  assign one_hot        = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);

  // Stability counter: restart at 1 on any change, otherwise count up and saturate.
  always_comb begin
    cnt_next = cnt_q;
    if (sample_changed)       cnt_next = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_next = cnt_q + CNT_W'(1);
  end

  // Fire only on the cycle the count arrives at the limit, never while it sits there.
  assign reach        = (cnt_next == CNT_MAX) && ((cnt_q != CNT_MAX) || sample_changed);
  assign capture      = reach && one_hot;
  assign capture_mask = capture ? an_act : '0;

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_next;
  end

  seg_pattern_decode u_decode (
    .seg_n (seg_s),
    .dec   (dec)
  );

  assign frame_done = &filled_q;
  assign load       = frame_done && (!out_valid || out_ready);

  // Digit slots: a capture writes its slot; a finished frame empties the filled mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slots are only a few flops, so they are reset with everything else; a RAM would not be.
      slot_digit_q <= '0;
      slot_err_q   <= '0;
      filled_q     <= '0;
    end else begin
      filled_q <= (frame_done ? '0 : filled_q) | capture_mask;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture_mask[i]) begin
          slot_digit_q[i] <= dec.digit;
          slot_err_q[i]   <= dec.err;
        end
      end
    end
  end

  // Output frame register and handshake; a frame that cannot load is dropped with an overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_digits <= '0;
      out_err    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= frame_done && out_valid && !out_ready;
      if (load) begin
        out_digits <= slot_digit_q;
        out_err    <= slot_err_q;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef SEG_READER_ERR_CNT_EN
  // Saturating count of captures whose pattern did not decode to a digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        err_count <= '0;
    else if (capture && dec.err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
// Frames are scanned digit by digit; the expected frame is derived from the
// segment table of each shown pattern, independent of the DUT's cycle timing.
module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [ND-1:0] an_in;
  logic [4*ND-1:0] out_digits;
  logic [ND-1:0] out_err;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
`ifdef SEG_READER_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  int checks   = 0;
  int failures = 0;
  int ov_cnt   = 0;
  int exp_err_cnt = 0;
  logic [6:0] frame_seg [ND];

  always #5 clk = ~clk;

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .out_digits (out_digits),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
`ifdef SEG_READER_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Active-low pattern that displays decimal digit d.
  function automatic logic [6:0] pat(input int d);
    return ~SEG_TAB[d];
  endfunction

  // Reference decode: which table entry (if any) the lit segments match.
  function automatic logic [3:0] model_digit(input logic [6:0] seg_n);
    for (int d = 0; d < 10; d++)
      if (~seg_n == SEG_TAB[d]) return 4'(d);
    return 4'hF;
  endfunction

  function automatic logic [3:0] an_for(input int i);
    logic [3:0] a;
    a = 4'hF;
    a[i] = 1'b0;
    return a;
  endfunction

  function automatic logic [4*ND-1:0] exp_digits();
    logic [4*ND-1:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = model_digit(frame_seg[i]);
    return v;
  endfunction

  function automatic logic [ND-1:0] exp_errs();
    logic [ND-1:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) v[i] = (model_digit(frame_seg[i]) == 4'hF);
    return v;
  endfunction

  // Hold the given bus value for n cycles, tallying overrun pulses.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) begin
      @(negedge clk);
      if (overrun === 1'b1) ov_cnt++;
    end
  endtask

  task automatic scan_digit(input int i, input int dwell);
    drive(an_for(i), frame_seg[i], dwell);
    if (model_digit(frame_seg[i]) == 4'hF && exp_err_cnt < 255) exp_err_cnt++;
  endtask

  task automatic scan_frame(input int dwell, input bit shuffle);
    int order [ND];
    for (int k = 0; k < ND; k++) order[k] = k;
    if (shuffle)
      for (int k = ND - 1; k > 0; k--) begin
        int j, t;
        j = $urandom_range(0, k);
        t = order[k]; order[k] = order[j]; order[j] = t;
      end
    drive(4'hF, 7'h7F, 2);
    for (int k = 0; k < ND; k++) scan_digit(order[k], dwell);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      @(negedge clk);
      if (overrun === 1'b1) ov_cnt++;
      k++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_digits"}, 32'(out_digits), 32'(exp_digits()));
    check({tag, "_err"}, 32'(out_err), 32'(exp_errs()));
`ifdef SEG_READER_ERR_CNT_EN
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_err_cnt));
`endif
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [4*ND-1:0] held_digits;
    logic [ND-1:0]   held_err;

    rst_n = 1'b0; seg_in = 7'h7F; an_in = 4'hF; out_ready = 1'b0;
    #1;
    check("reset_digits", 32'(out_digits), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scan "1234".
    frame_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
    scan_frame(8, 1'b0);
    wait_valid("scan1234");
    check("scan1234_const", 32'(out_digits), 32'h4321);
    check_frame("scan1234");
    consume("scan1234");

    // Two-cycle glitch to an "8" inside digit 1's window must not be captured.
    frame_seg = '{pat(5), pat(6), pat(7), pat(9)};
    drive(4'hF, 7'h7F, 2);
    scan_digit(0, 8);
    drive(an_for(1), frame_seg[1], 8);
    drive(an_for(1), 7'h00, 2);
    drive(an_for(1), frame_seg[1], 8);
    scan_digit(2, 8);
    scan_digit(3, 8);
    wait_valid("glitch");
    check_frame("glitch");
    consume("glitch");

    // Undecodable pattern in digit 2.
    frame_seg = '{pat(0), pat(8), 7'h7E, pat(3)};
    scan_frame(8, 1'b0);
    wait_valid("invalid");
    check("invalid_nibble", 32'(out_digits[11:8]), 32'hF);
    check("invalid_err_const", 32'(out_err), 32'b0100);
    check_frame("invalid");
    consume("invalid");

    // Backpressure: first frame held, second dropped with one overrun pulse.
    ov_cnt = 0;
    frame_seg = '{pat(2), pat(4), pat(6), pat(8)};
    scan_frame(8, 1'b0);
    wait_valid("bp_first");
    check_frame("bp_first");
    held_digits = exp_digits();
    held_err    = exp_errs();
    frame_seg = '{pat(1), pat(3), pat(5), pat(7)};
    scan_frame(8, 1'b0);
    drive(4'hF, 7'h7F, 10);
    check("bp_overrun_pulses", 32'(ov_cnt), 32'd1);
    check("bp_held_digits", 32'(out_digits), 32'(held_digits));
    check("bp_held_err", 32'(out_err), 32'(held_err));
    check("bp_held_valid", 32'(out_valid), 32'd1);
    consume("bp");

    // Zero / multiple active anodes between partial scans must not capture.
    frame_seg = '{pat(9), pat(1), pat(0), pat(4)};
    drive(4'hF, 7'h7F, 2);
    scan_digit(0, 8);
    scan_digit(1, 8);
    drive(4'b1100, pat(7), 20);
    drive(4'b1111, pat(7), 20);
    check("anodes_no_frame", 32'(out_valid), 32'd0);
    scan_digit(2, 8);
    scan_digit(3, 8);
    wait_valid("anodes");
    check_frame("anodes");
    consume("anodes");

    // Reset mid-frame: outputs clear immediately; captured slots are discarded.
    frame_seg = '{pat(3), pat(3), pat(7), pat(1)};
    scan_frame(8, 1'b0);
    wait_valid("pre_reset");
    frame_seg = '{pat(6), pat(2), pat(8), pat(5)};
    drive(4'hF, 7'h7F, 2);
    scan_digit(0, 8);
    scan_digit(1, 8);
    an_in = 4'hF; seg_in = 7'h7F;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_digits", 32'(out_digits), 32'd0);
    check("midreset_err", 32'(out_err), 32'd0);
    check("midreset_valid", 32'(out_valid), 32'd0);
    exp_err_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    scan_digit(2, 8);
    scan_digit(3, 8);
    drive(4'hF, 7'h7F, 20);
    check("midreset_partial_discarded", 32'(out_valid), 32'd0);
    scan_digit(0, 8);
    scan_digit(1, 8);
    wait_valid("postreset");
    check_frame("postreset");
    consume("postreset");

    // Randomized frames: random digits or raw patterns, random scan order and dwell.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < ND; i++)
        frame_seg[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : pat($urandom_range(0, 9));
      scan_frame($urandom_range(8, 12), 1'b1);
      wait_valid($sformatf("rand%0d", f));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_frame($sformatf("rand%0d", f));
      consume($sformatf("rand%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
